// File: rtl/mips_cpu_bus_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store, sequencing one
// Avalon transfer at a time and returning a registered one-cycle acknowledge.
//
// state  | meaning
// S_IDLE | bus free; sample both requests, grant one
// S_BUS  | Avalon strobe and payload held until waitrequest falls
// S_RESP | one-cycle ack with captured read data to the owner
module mips_cpu_bus_arbiter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ifetch_req_i,
  input  logic [31:0] ifetch_addr_i,
  output logic        ifetch_ack_o,
  output logic [31:0] ifetch_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_be_i,
  output logic        data_ack_o,
  output logic [31:0] data_rdata_o,
  output logic [31:0] address_o,
  output logic        read_o,
  output logic        write_o,
  output logic [31:0] writedata_o,
  output logic [3:0]  byteenable_o,
  input  logic        waitrequest_i,
  input  logic [31:0] readdata_i,
  output logic        bus_busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        owner_data_q, owner_data_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic        ifetch_ack_q, ifetch_ack_d;
  logic        data_ack_q, data_ack_d;
  logic [31:0] ifetch_rdata_q, ifetch_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        grant_data;

  // last_grant_q = 1 means data was granted last, so fetch wins the next tie.
  assign grant_data = data_req_i && (!ifetch_req_i || !last_grant_q);

  always_comb begin
    state_d        = state_q;
    owner_data_d   = owner_data_q;
    last_grant_d   = last_grant_q;
    address_d      = address_q;
    read_d         = read_q;
    write_d        = write_q;
    writedata_d    = writedata_q;
    byteenable_d   = byteenable_q;
    ifetch_ack_d   = 1'b0;
    data_ack_d     = 1'b0;
    ifetch_rdata_d = ifetch_rdata_q;
    data_rdata_d   = data_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (ifetch_req_i || data_req_i) begin
          owner_data_d = grant_data;
          last_grant_d = grant_data;
          state_d      = S_BUS;
          if (grant_data) begin
            address_d    = data_addr_i;
            read_d       = ~data_we_i;
            write_d      = data_we_i;
            writedata_d  = data_wdata_i;
            byteenable_d = data_be_i;
          end else begin
            address_d    = ifetch_addr_i;
            read_d       = 1'b1;
            write_d      = 1'b0;
            writedata_d  = 32'd0;
            byteenable_d = 4'hF;
          end
        end
      end

      S_BUS: begin
        if (!waitrequest_i) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = S_RESP;
          if (owner_data_q) begin
            data_ack_d   = 1'b1;
            data_rdata_d = read_q ? readdata_i : 32'd0;
          end else begin
            ifetch_ack_d   = 1'b1;
            ifetch_rdata_d = readdata_i;
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      owner_data_q   <= 1'b0;
      last_grant_q   <= 1'b1;
      address_q      <= 32'd0;
      read_q         <= 1'b0;
      write_q        <= 1'b0;
      writedata_q    <= 32'd0;
      byteenable_q   <= 4'd0;
      ifetch_ack_q   <= 1'b0;
      data_ack_q     <= 1'b0;
      ifetch_rdata_q <= 32'd0;
      data_rdata_q   <= 32'd0;
    end else begin
      state_q        <= state_d;
      owner_data_q   <= owner_data_d;
      last_grant_q   <= last_grant_d;
      address_q      <= address_d;
      read_q         <= read_d;
      write_q        <= write_d;
      writedata_q    <= writedata_d;
      byteenable_q   <= byteenable_d;
      ifetch_ack_q   <= ifetch_ack_d;
      data_ack_q     <= data_ack_d;
      ifetch_rdata_q <= ifetch_rdata_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  assign ifetch_ack_o   = ifetch_ack_q;
  assign ifetch_rdata_o = ifetch_rdata_q;
  assign data_ack_o     = data_ack_q;
  assign data_rdata_o   = data_rdata_q;
  assign address_o      = address_q;
  assign read_o         = read_q;
  assign write_o        = write_q;
  assign writedata_o    = writedata_q;
  assign byteenable_o   = byteenable_q;
  assign bus_busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Directed and randomized transfers against a transaction-level model of the
// round-robin fetch/data bus arbiter.
module tb_mips_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifetch_req;
  logic [31:0] ifetch_addr;
  logic        ifetch_ack;
  logic [31:0] ifetch_rdata;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        bus_busy;

  int checks = 0;
  int failures = 0;

  // model state: which requests are outstanding, their payloads, who won last
  bit          pend_f, pend_d;
  bit          last_was_data;
  logic [31:0] pf_addr, pd_addr, pd_wdata;
  bit          pd_we;
  logic [3:0]  pd_be;
  logic [31:0] f_rdata_m, d_rdata_m;

  mips_cpu_bus_arbiter dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .ifetch_req_i   (ifetch_req),
    .ifetch_addr_i  (ifetch_addr),
    .ifetch_ack_o   (ifetch_ack),
    .ifetch_rdata_o (ifetch_rdata),
    .data_req_i     (data_req),
    .data_we_i      (data_we),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_be_i      (data_be),
    .data_ack_o     (data_ack),
    .data_rdata_o   (data_rdata),
    .address_o      (address),
    .read_o         (read),
    .write_o        (write),
    .writedata_o    (writedata),
    .byteenable_o   (byteenable),
    .waitrequest_i  (waitrequest),
    .readdata_i     (readdata),
    .bus_busy_o     (bus_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the falling edge of an IDLE cycle; returns at the falling edge
  // of the following IDLE cycle with the winner's request dropped.
  task automatic xfer(input bit new_f, input logic [31:0] fa,
                      input bit new_d, input bit dwe, input logic [31:0] da,
                      input logic [31:0] dwd, input logic [3:0] dbe,
                      input bit late_f, input logic [31:0] late_fa,
                      input int nwait, input logic [31:0] rd);
    bit          win_d;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    bit          e_rd, e_wr;
    chk("idle_busy", 32'(bus_busy), 0);
    chk("idle_read", 32'(read), 0);
    chk("idle_write", 32'(write), 0);
    chk("idle_fack", 32'(ifetch_ack), 0);
    chk("idle_dack", 32'(data_ack), 0);
    chk("hold_frdata", ifetch_rdata, f_rdata_m);
    chk("hold_drdata", data_rdata, d_rdata_m);
    if (new_f && !pend_f) begin
      pend_f = 1; pf_addr = fa;
      ifetch_req = 1; ifetch_addr = fa;
    end
    if (new_d && !pend_d) begin
      pend_d = 1; pd_we = dwe; pd_addr = da; pd_wdata = dwd; pd_be = dbe;
      data_req = 1; data_we = dwe; data_addr = da; data_wdata = dwd; data_be = dbe;
    end
    win_d = pend_d && (!pend_f || !last_was_data);
    last_was_data = win_d;
    if (win_d) begin
      e_addr = pd_addr; e_rd = !pd_we; e_wr = pd_we; e_be = pd_be; e_wd = pd_wdata;
    end else begin
      e_addr = pf_addr; e_rd = 1; e_wr = 0; e_be = 4'hF; e_wd = 0;
    end
    step();
    if (late_f && !pend_f) begin
      pend_f = 1; pf_addr = late_fa;
      ifetch_req = 1; ifetch_addr = late_fa;
    end
    for (int k = 0; k <= nwait; k++) begin
      chk("bus_busy", 32'(bus_busy), 1);
      chk("bus_addr", address, e_addr);
      chk("bus_read", 32'(read), 32'(e_rd));
      chk("bus_write", 32'(write), 32'(e_wr));
      chk("bus_be", 32'(byteenable), 32'(e_be));
      chk("bus_wdata", writedata, e_wd);
      chk("bus_fack", 32'(ifetch_ack), 0);
      chk("bus_dack", 32'(data_ack), 0);
      waitrequest = (k < nwait);
      readdata = (k < nwait) ? $urandom : rd;
      step();
    end
    waitrequest = 0;
    readdata = $urandom;
    chk("resp_busy", 32'(bus_busy), 1);
    chk("resp_read", 32'(read), 0);
    chk("resp_write", 32'(write), 0);
    chk("resp_fack", 32'(ifetch_ack), 32'(!win_d));
    chk("resp_dack", 32'(data_ack), 32'(win_d));
    if (win_d) d_rdata_m = pd_we ? 32'd0 : rd;
    else       f_rdata_m = rd;
    chk("resp_frdata", ifetch_rdata, f_rdata_m);
    chk("resp_drdata", data_rdata, d_rdata_m);
    step();
    if (win_d) begin pend_d = 0; data_req = 0; end
    else       begin pend_f = 0; ifetch_req = 0; end
  endtask

  initial begin
    reset = 1; ifetch_req = 0; ifetch_addr = 0; data_req = 0; data_we = 0;
    data_addr = 0; data_wdata = 0; data_be = 0; waitrequest = 0; readdata = 0;
    pend_f = 0; pend_d = 0; last_was_data = 1; f_rdata_m = 0; d_rdata_m = 0;
    @(negedge clk);
    step();
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_busy", 32'(bus_busy), 0);
      chk("rst_strobes", {30'd0, read, write}, 0);
      chk("rst_addr", address, 0);
      chk("rst_wdata", writedata, 0);
      chk("rst_be", 32'(byteenable), 0);
      chk("rst_acks", {30'd0, ifetch_ack, data_ack}, 0);
      chk("rst_rdata", ifetch_rdata | data_rdata, 0);
    end

    // single fetch, zero wait states
    xfer(1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h24020005);
    // data write with three wait states and partial byte enables
    xfer(0, 0, 1, 1, 32'h1000, 32'hDEADBEEF, 4'b0011, 0, 0, 3, 32'h55AA55AA);
    // zero byte enables pass through unchanged
    xfer(0, 0, 1, 1, 32'h1004, 32'h01020304, 4'b0000, 0, 0, 1, 32'h0);
    // continuous contention from a fresh tie: F, D, F, D
    xfer(1, 32'h100, 1, 0, 32'h3000, 0, 4'hF, 0, 0, 0, 32'hA0000001);
    xfer(1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA0000002);
    xfer(0, 0, 1, 0, 32'h3004, 0, 4'hF, 0, 0, 0, 32'hA0000003);
    xfer(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA0000004);
    // data read while a fetch arrives during the bus phase
    xfer(0, 0, 1, 0, 32'h2000, 0, 4'hF, 1, 32'h108, 2, 32'h12345678);
    chk("late_drdata", data_rdata, 32'h12345678);
    xfer(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0BADF00D);

    // reset in the middle of a stalled bus phase
    ifetch_req = 1; ifetch_addr = 32'h200;
    step();
    chk("rb_read", 32'(read), 1);
    waitrequest = 1; reset = 1;
    step();
    chk("rb_strobes", {30'd0, read, write}, 0);
    chk("rb_acks", {30'd0, ifetch_ack, data_ack}, 0);
    chk("rb_busy", 32'(bus_busy), 0);
    reset = 0; waitrequest = 0; ifetch_req = 0;
    pend_f = 0; pend_d = 0; last_was_data = 1; f_rdata_m = 0; d_rdata_m = 0;
    step();
    chk("rb_noack", {30'd0, ifetch_ack, data_ack}, 0);
    xfer(1, 32'h204, 1, 1, 32'h40, 32'hCAFEF00D, 4'b1100, 0, 0, 2, 32'h77777777);
    xfer(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      bit nf, nd, lf;
      nf = $urandom_range(0, 1);
      nd = $urandom_range(0, 1);
      lf = ($urandom_range(0, 3) == 0);
      if (!pend_f && !pend_d && !nf && !nd) nf = 1;
      xfer(nf, {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
           nd, 1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
           $urandom, 4'($urandom_range(0, 15)),
           lf, {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
           $urandom_range(0, 4), $urandom);
    end
    while (pend_f || pend_d)
      xfer(0, 0, 0, 0, 0, 0, 0, 0, 0, $urandom_range(0, 2), $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus_arbiter.md
# mips_cpu_bus_arbiter

Two-port arbiter and Avalon master sequencer that shares the CPU's single memory-mapped bus between the instruction-fetch path and the load/store data path. Sits between the CPU control FSM and the Avalon controller ports of `mips_cpu_bus`. It latches one request at a time, drives a compliant Avalon read or write, holds it through `waitrequest`, and returns a one-cycle acknowledge with registered read data to the granted requester. Simultaneous requests are resolved round-robin.

## Interface
- No parameters.
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `ifetch_req`  in  1  fetch request; held high, payload stable, until `ifetch_ack`
- `ifetch_addr`  in  32  fetch byte address (word aligned)
- `ifetch_ack`  out  1  one-cycle completion pulse
- `ifetch_rdata`  out  32  fetched word; valid while `ifetch_ack`=1
- `data_req`  in  1  data request; same holding rule
- `data_we`  in  1  1 = write, 0 = read
- `data_addr`  in  32  data byte address (word aligned)
- `data_wdata`  in  32  write data
- `data_be`  in  4  byte enables for the data access
- `data_ack`  out  1  one-cycle completion pulse
- `data_rdata`  out  32  read word; valid while `data_ack`=1 and access was a read, else 0
- `address`  out  32  Avalon address
- `read`  out  1  Avalon read strobe
- `write`  out  1  Avalon write strobe
- `writedata`  out  32  Avalon write data
- `byteenable`  out  4  Avalon byte enables
- `waitrequest`  in  1  slave stall
- `readdata`  in  32  slave read data, valid in the cycle with `read`=1 and `waitrequest`=0
- `bus_busy`  out  1  1 whenever state ≠ IDLE

## Operation
- States: IDLE, BUS, RESP.
- IDLE: sample requests. None -> stay. Only one -> grant it. Both -> grant the port not granted last (`last_grant` bit). On grant: register address, direction, writedata, byteenable, grant owner; go BUS; update `last_grant`.
- Fetch grant: `read`=1, `write`=0, `byteenable`=4'b1111, `writedata`=0.
- Data grant: `read`=~`data_we`, `write`=`data_we`, `byteenable`=`data_be`, `writedata`=`data_wdata`. `data_be`=0 is still issued unchanged.
- BUS: strobes and payload held constant while `waitrequest`=1 (unbounded). On `waitrequest`=0: capture `readdata` (reads only), drop strobes, go RESP.
- RESP: assert owner's ack for exactly one cycle with captured data on owner's rdata; the other port's ack stays 0. Go IDLE.
- Requester protocol: keep `req` high through the ack cycle, deassert from the next cycle. A req still high in the IDLE after RESP is a new request.
- Requests arriving in BUS/RESP are not lost; they are sampled in the next IDLE.
- Addresses passed unmodified; no alignment checking.
- rdata outputs hold their last value outside ack cycles.

## Timing
- Reset (synchronous): state IDLE, `last_grant`=data (so fetch wins first tie); `address`, `writedata`=0; `read`, `write`=0; `byteenable`=0; both acks 0; both rdata 0; `bus_busy`=0.
- Reset during BUS or RESP: abort at that edge; strobes low and acks low next cycle; pending transfer not acknowledged.
- All outputs registered; no combinational path from requester inputs or `waitrequest` to any output.
- Latency, zero wait states: req sampled in IDLE cycle 0 -> strobe cycle 1 -> ack cycle 2 -> IDLE cycle 3. Each wait-state cycle adds one.
- Throughput: one transfer per 3 cycles minimum; continuous contention alternates F, D, F, D.

## Test plan
- Reset, then idle 5 cycles -> all outputs 0, `bus_busy`=0, no strobes.
- Fetch `ifetch_addr`=0xBFC00000, `waitrequest`=0, `readdata`=0x24020005 -> `read`=1, `byteenable`=4'hF in cycle 1; `ifetch_ack`=1, `ifetch_rdata`=0x24020005 in cycle 2; `data_ack` stays 0.
- Data write `data_addr`=0x1000, `data_wdata`=0xDEADBEEF, `data_be`=4'b0011, `waitrequest` high 3 cycles -> `write`=1 and payload stable 4 cycles, `read`=0, `data_ack` one cycle after `waitrequest` falls.
- Both requesting from reset, held continuously -> grants F, D, F, D; each ack is exactly one cycle; no cycle with `read` and `write` both 1.
- Data read 0x2000 returning 0x12345678 while fetch request arrives during BUS -> data completes first, fetch begins in following IDLE, `data_rdata`=0x12345678.
- Reset asserted in BUS while `waitrequest`=1 -> strobes 0 next cycle, no ack, next request after reset served normally.
